// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack multiply coprocessor.
// Holds the FSM state encoding and the ALU control words used by the sequencer.
package hack_pkg;

  localparam int WORD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] ALU_ADD   = 6'b000010;
  localparam logic [5:0] ALU_PASSX = 6'b001010;
  localparam logic [5:0] ALU_NOP   = 6'b000000;

endpackage

// File: rtl/hack_mul_seq_alu.sv
// Hack ALU: zx nx zy ny f no control, combinational.
// Control bit order is ctl[5:0] = {zx, nx, zy, ny, f, no}.
module hack_mul_seq_alu
  import hack_pkg::*;
(
  input  logic [WORD-1:0] x,
  input  logic [WORD-1:0] y,
  input  logic [5:0]      ctl,
  output logic [WORD-1:0] out,
  output logic            zr,
  output logic            ng
);

  logic [WORD-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = ctl[5] ? '0 : x;
    xn  = ctl[4] ? ~xz : xz;
    yz  = ctl[3] ? '0 : y;
    yn  = ctl[2] ? ~yz : yz;
    fo  = ctl[1] ? (xn + yn) : (xn & yn);
    out = ctl[0] ? ~fo : fo;
  end

  assign zr = (out == '0);
  assign ng = out[WORD-1];

endmodule

// File: rtl/hack_mul_seq.sv
// Shift-and-add 16x16 multiplier sequencing one shared Hack ALU.
// Fixed 33-edge latency from accepted start to the done cycle.
module hack_mul_seq
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEPS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             zr,
  output logic             ng
);

  state_t           state;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [3:0]       count;

  logic [WIDTH-1:0] alu_x, alu_y, alu_out;
  logic [5:0]       alu_ctl;
  logic             unused_zr, unused_ng;

  // ADD accumulates (or passes acc through); DBL doubles mcand.
  always_comb begin
    alu_x   = acc;
    alu_y   = mcand;
    alu_ctl = ALU_NOP;
    unique case (state)
      ADD: alu_ctl = mplier[0] ? ALU_ADD : ALU_PASSX;
      DBL: begin
        alu_x   = mcand;
        alu_ctl = ALU_ADD;
      end
      default: alu_ctl = ALU_NOP;
    endcase
  end

  hack_mul_seq_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .ctl (alu_ctl),
    .out (alu_out),
    .zr  (unused_zr),
    .ng  (unused_ng)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            count  <= '0;
            state  <= ADD;
          end
        end
        ADD: begin
          acc   <= alu_out;
          state <= DBL;
        end
        DBL: begin
          mcand  <= alu_out;
          mplier <= mplier >> 1;
          if (count == 4'(STEPS - 1)) begin
            state <= DONE;
          end else begin
            count <= count + 4'd1;
            state <= ADD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready   = (state == IDLE);
  assign busy    = (state == ADD) || (state == DBL);
  assign done    = (state == DONE);
  assign product = acc;
  assign zr      = (acc == '0);
  assign ng      = acc[WIDTH-1];

endmodule

// File: tb/tb_hack_mul_seq.sv
// Self-checking bench for hack_mul_seq: vector table, random ops vs
// an arithmetic model, and hand-written handshake/reset sequences.
module tb_hack_mul_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] a, b;
  logic        ready, busy, done, zr, ng;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  hack_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zr      (zr),
    .ng      (ng)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] p;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [15:0] y);
    int unsigned full;
    full = int'(x) * int'(y);
    return full[15:0];
  endfunction

  // Entered and left at a negedge with the block idle.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2,
                        input logic [15:0] ep, input logic ez,
                        input logic en, input bit poke, input string nm);
    int lat;
    int bcnt;
    a = ta;
    b = tb2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    check({nm, "_ready_drop"}, 32'(ready), 32'd0);
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      start = 1'b0;
      if (poke && (lat == 5 || lat == 20)) begin
        start = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'd33);
    check({nm, "_busy_cycles"}, 32'(bcnt), 32'd32);
    check({nm, "_product"}, 32'(product), 32'(ep));
    check({nm, "_zr"}, 32'(zr), 32'(ez));
    check({nm, "_ng"}, 32'(ng), 32'(en));
    if (poke) begin
      start = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    check({nm, "_done_once"}, 32'(done), 32'd0);
    check({nm, "_ready_back"}, 32'(ready), 32'd1);
    check({nm, "_held"}, 32'(product), 32'(ep));
    if (poke) begin
      repeat (3) begin
        @(negedge clk);
        check({nm, "_idle_ready"}, 32'(ready), 32'd1);
        check({nm, "_idle_held"}, 32'(product), 32'(ep));
      end
    end
  endtask

  initial begin
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ra, rb, rp, ea, eb, ep;
    bit          saw;

    vt[0] = '{16'd3,     16'd5,     16'd15,    1'b0, 1'b0};
    vt[1] = '{16'd300,   16'd300,   16'd24464, 1'b0, 1'b0};
    vt[2] = '{16'hFFFF,  16'hFFFF,  16'h0001,  1'b0, 1'b0};
    vt[3] = '{16'hFFFD,  16'd7,     16'hFFEB,  1'b0, 1'b1};
    vt[4] = '{16'd0,     16'h1234,  16'd0,     1'b1, 1'b0};
    vt[5] = '{16'd2,     16'd9,     16'd18,    1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_zr", 32'(zr), 32'd1);
    check("rst_ng", 32'(ng), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(ready), 32'd1);

    for (int i = 0; i < 6; i++)
      run_op(vt[i].va, vt[i].vb, vt[i].p, vt[i].z, vt[i].n, 1'b0,
             $sformatf("vec%0d", i));

    // Starts during ADD/DBL and in DONE must be ignored.
    run_op(16'd123, 16'd45, 16'd5535, 1'b0, 1'b0, 1'b1, "poke");

    // Reset mid-operation abandons it without a done pulse.
    a = 16'd7;
    b = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_zr", 32'(zr), 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    check("midrst_no_done", 32'(saw), 32'd0);
    run_op(16'd2, 16'd9, 16'd18, 1'b0, 1'b0, 1'b0, "after_rst");

    // Random operands against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      rp = model(ra, rb);
      run_op(ra, rb, rp, rp == 16'd0, rp[15], 1'b0,
             $sformatf("rnd%0d", i));
    end

    // start held high: one accept every 34 edges, back to back.
    start = 1'b1;
    for (int j = 0; j < 136; j++) begin
      check($sformatf("b2b_ready_%0d", j), 32'(ready),
            32'(j % 34 == 0));
      check($sformatf("b2b_done_%0d", j), 32'(done),
            32'(j % 34 == 33));
      if (j % 34 == 33) begin
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          ep = model(ea, eb);
          check($sformatf("b2b_product_%0d", j), 32'(product), 32'(ep));
        end else begin
          check("b2b_queue_empty", 32'd1, 32'd0);
        end
      end
      a = 16'($urandom);
      b = 16'($urandom);
      if (j % 34 == 0) begin
        qa.push_back(a);
        qb.push_back(b);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_end_ready", 32'(ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
